mem_arbiter: RTL and testbench

//  Two-requester arbiter sharing the single processor-style memory port (addr/rstrb/rdata/wmask/wdata).

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single processor-style memory port.
// Requester 0 is the processor and requester 1 a secondary master. One access is granted at a time.
// A read holds the port for one extra cycle (RD_WAIT) and its data is routed back to the owner.
// Define MEM_ARB_FIXED_PRIO_EN to make m0 always win ties. The default is round-robin.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W/8-1:0] m0_wmask_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_rvalid_o,
  input  logic                m1_req_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_wmask_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_rvalid_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_rstrb_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  output logic [DATA_W-1:0]   mem_wdata_o
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t              state_r;
  logic                owner_r;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                last_r;
`endif

  logic                winner;
  logic                grant;
  logic                sel_read;
  logic [ADDR_W-1:0]   sel_addr;
  logic [MASK_W-1:0]   sel_wmask;
  logic [DATA_W-1:0]   sel_wdata;

  // Pick the winner among the active requests and mux its payload.
  always_comb begin
    winner = 1'b0;
    if (m0_req_i && m1_req_i) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_r;
`endif
    end else if (m1_req_i) begin
      winner = 1'b1;
    end
    sel_addr  = winner ? m1_addr_i  : m0_addr_i;
    sel_wmask = winner ? m1_wmask_i : m0_wmask_i;
    sel_wdata = winner ? m1_wdata_i : m0_wdata_i;
    sel_read  = (sel_wmask == '0);
    // Outputs are gated by rst_i so everything reads zero while reset is held.
    grant     = (state_r == IDLE) && (m0_req_i || m1_req_i) && !rst_i;
  end

  // Drive grants, the memory port, and read-data routing for the current state.
  always_comb begin
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    mem_addr_o  = '0;
    mem_rstrb_o = 1'b0;
    mem_wmask_o = '0;
    mem_wdata_o = '0;
    if (grant) begin
      m0_gnt_o    = ~winner;
      m1_gnt_o    = winner;
      mem_addr_o  = sel_addr;
      mem_wdata_o = sel_wdata;
      mem_rstrb_o = sel_read;
      mem_wmask_o = sel_read ? '0 : sel_wmask;
    end else if (state_r == RD_WAIT && !rst_i) begin
      if (owner_r) begin
        m1_rvalid_o = 1'b1;
        m1_rdata_o  = mem_rdata_i;
      end else begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = mem_rdata_i;
      end
    end
  end

  // State, read owner and round-robin history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_r  <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_r <= winner;
`endif
            if (sel_read) begin
              owner_r <= winner;
              state_r <= RD_WAIT;
            end
          end
        end
        RD_WAIT: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, memory port muxing, read-data routing and reset behaviour.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [3:0]  m0_wmask_i = '0, m1_wmask_i = '0;
  logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rstrb_o;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  mem_wmask_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wmask_i(m0_wmask_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rdata_o(m0_rdata_o), .m0_rvalid_o(m0_rvalid_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wmask_i(m1_wmask_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rdata_o(m1_rdata_o), .m1_rvalid_o(m1_rvalid_o),
    .mem_addr_o(mem_addr_o), .mem_rstrb_o(mem_rstrb_o), .mem_rdata_i(mem_rdata_i),
    .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Settle the combinational outputs, away from both clock edges.
  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    chk({tag, "_gnt0"}, {31'd0, m0_gnt_o}, {31'd0, g0});
    chk({tag, "_gnt1"}, {31'd0, m1_gnt_o}, {31'd0, g1});
  endtask

  task automatic chk_rv(input string tag, input logic v0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] d1);
    chk({tag, "_rv0"}, {31'd0, m0_rvalid_o}, {31'd0, v0});
    chk({tag, "_rd0"}, m0_rdata_o, d0);
    chk({tag, "_rv1"}, {31'd0, m1_rvalid_o}, {31'd0, v1});
    chk({tag, "_rd1"}, m1_rdata_o, d1);
  endtask

  initial begin
    logic exp_w;

    // Reset held with a live request: everything must stay at zero.
    m0_req_i = 1'b1; m0_addr_i = 32'h55; m0_wdata_i = 32'h77;
    #1; settle();
    chk_gnt("rst", 1'b0, 1'b0);
    chk_rv("rst", 1'b0, '0, 1'b0, '0);
    chk("rst_rstrb", {31'd0, mem_rstrb_o}, 32'd0);
    chk("rst_wmask", {28'd0, mem_wmask_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    m0_req_i = 1'b0;
    next_cycle();
    rst_i = 1'b0;

    // Idle with no request.
    settle();
    chk_gnt("idle", 1'b0, 1'b0);
    chk("idle_addr", mem_addr_o, 32'd0);

    // 1. m0 single read of 0x10.
    next_cycle();
    m0_req_i = 1'b1; m0_addr_i = 32'h10; m0_wmask_i = 4'h0;
    settle();
    chk_gnt("t1", 1'b1, 1'b0);
    chk("t1_rstrb", {31'd0, mem_rstrb_o}, 32'd1);
    chk("t1_addr", mem_addr_o, 32'h10);
    chk("t1_wmask", {28'd0, mem_wmask_o}, 32'd0);
    next_cycle();
    m0_req_i = 1'b0; mem_rdata_i = 32'hDEADBEEF;
    settle();
    chk_gnt("t1w", 1'b0, 1'b0);
    chk("t1w_rstrb", {31'd0, mem_rstrb_o}, 32'd0);
    chk_rv("t1w", 1'b1, 32'hDEADBEEF, 1'b0, '0);
    next_cycle();
    mem_rdata_i = 32'hCAFEF00D;
    settle();
    chk_rv("t1x", 1'b0, '0, 1'b0, '0);

    // 2. m1 partial write, then confirm the arbiter stays in IDLE.
    next_cycle();
    m1_req_i = 1'b1; m1_addr_i = 32'h20; m1_wmask_i = 4'b0011; m1_wdata_i = 32'h1234;
    settle();
    chk_gnt("t2", 1'b0, 1'b1);
    chk("t2_wmask", {28'd0, mem_wmask_o}, 32'h3);
    chk("t2_rstrb", {31'd0, mem_rstrb_o}, 32'd0);
    chk("t2_addr", mem_addr_o, 32'h20);
    chk("t2_wdata", mem_wdata_o, 32'h1234);
    next_cycle();
    m1_req_i = 1'b0; m1_wmask_i = 4'h0;
    m0_req_i = 1'b1; m0_addr_i = 32'h24;
    settle();
    chk_rv("t2n", 1'b0, '0, 1'b0, '0);
    chk_gnt("t2n", 1'b1, 1'b0);
    next_cycle();
    m0_req_i = 1'b0;

    // 3. Both read continuously after reset: alternating owners, two cycles each.
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 32'h100; m0_wmask_i = 4'h0;
    m1_req_i = 1'b1; m1_addr_i = 32'h200; m1_wmask_i = 4'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_w = 1'b0;
`else
      exp_w = k[0];
`endif
      settle();
      chk_gnt("t3g", ~exp_w, exp_w);
      chk("t3_rstrb", {31'd0, mem_rstrb_o}, 32'd1);
      chk("t3_addr", mem_addr_o, exp_w ? 32'h200 : 32'h100);
      next_cycle();
      mem_rdata_i = 32'hA000_0000 + 32'(k);
      settle();
      chk_gnt("t3w", 1'b0, 1'b0);
      chk_rv("t3w", ~exp_w, exp_w ? 32'd0 : 32'hA000_0000 + 32'(k),
             exp_w, exp_w ? 32'hA000_0000 + 32'(k) : 32'd0);
      next_cycle();
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;

    // 4. Both write continuously: one grant per cycle.
    do_reset();
    m0_req_i = 1'b1; m0_wmask_i = 4'hF; m0_wdata_i = 32'h1111_1111; m0_addr_i = 32'h8;
    m1_req_i = 1'b1; m1_wmask_i = 4'hF; m1_wdata_i = 32'h2222_2222; m1_addr_i = 32'hC;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_w = 1'b0;
`else
      exp_w = k[0];
`endif
      settle();
      chk_gnt("t4", ~exp_w, exp_w);
      chk("t4_wdata", mem_wdata_o, exp_w ? 32'h2222_2222 : 32'h1111_1111);
      chk("t4_wmask", {28'd0, mem_wmask_o}, 32'hF);
      chk("t4_rstrb", {31'd0, mem_rstrb_o}, 32'd0);
      next_cycle();
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    m0_wmask_i = 4'h0; m1_wmask_i = 4'h0;

    // 5. Reset during RD_WAIT drops the read, and the next tie goes to m0.
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 32'h40;
    settle();
    chk_gnt("t5g", 1'b1, 1'b0);
    next_cycle();
    m0_req_i = 1'b0; mem_rdata_i = 32'h5555_AAAA;
    rst_i = 1'b1;
    settle();
    chk_rv("t5r", 1'b0, '0, 1'b0, '0);
    next_cycle();
    rst_i = 1'b0;
    m0_req_i = 1'b1; m1_req_i = 1'b1; m0_addr_i = 32'h44; m1_addr_i = 32'h48;
    settle();
    chk_gnt("t5tie", 1'b1, 1'b0);
    next_cycle();
    m0_req_i = 1'b0; m1_req_i = 1'b0;

    // 6. m1 held while m0 re-requests right after its read: m1 must get the next slot.
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 32'h30;
    settle();
    chk_gnt("t6a", 1'b1, 1'b0);
    next_cycle();
    m1_req_i = 1'b1; m1_addr_i = 32'h34;
    settle();
    chk_gnt("t6w", 1'b0, 1'b0);
    next_cycle();
    settle();
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk_gnt("t6b", 1'b1, 1'b0);
    chk("t6_addr", mem_addr_o, 32'h30);
`else
    chk_gnt("t6b", 1'b0, 1'b1);
    chk("t6_addr", mem_addr_o, 32'h34);
`endif
    next_cycle();
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
